// File: rtl/core_regfile_pkg.sv
// Shared constants and helpers for the multi-port register file: address width,
// the hard-wired zero register and the highest-index-wins port selector.
package core_regfile_pkg;

  localparam int REG_ZERO  = 0;
  localparam int MAX_PORTS = 4;

  function automatic int unsigned regfile_aw(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

  // Highest set request bit wins; callers only consult the result when req != 0.
  function automatic int unsigned prio_sel(input logic [MAX_PORTS-1:0] req);
    int unsigned idx = 0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      if (req[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/core_regfile_if.sv
// Read/write/issue bundle of the register file; master = pipeline side, slave = register file.
interface core_regfile_if #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
);
  import core_regfile_pkg::*;
  localparam int AW = regfile_aw(NREGS);

  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic [NRD-1:0]      rs_perr;
  logic [NWR-1:0]      rd_wen;
  logic [NWR*AW-1:0]   rd_addr;
  logic [NWR*XLEN-1:0] rd_wdata;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic                busy_any;

  modport master (
    output rs_addr, rd_wen, rd_addr, rd_wdata, iss_en, iss_addr, flush,
    input  rs_data, rs_busy, rs_perr, busy_any
  );

  modport slave (
    input  rs_addr, rd_wen, rd_addr, rd_wdata, iss_en, iss_addr, flush,
    output rs_data, rs_busy, rs_perr, busy_any
  );

endinterface

// File: rtl/core_regfile_sb.sv
// Pending-write scoreboard: one bit per register, flush -> writeback clear -> issue set.
module core_regfile_sb
  import core_regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int NWR   = 1,
  parameter int AW    = 5
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              flush,
  input  logic [NWR-1:0]    clr_en,
  input  logic [NWR*AW-1:0] clr_addr,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  output logic [NREGS-1:0]  pending,
  output logic              busy_any
);

  logic [NREGS-1:0] pending_nxt;

  always_comb begin
    // NOTE: the full default comes first so every path assigns pending_nxt and no latch is inferred.
    pending_nxt = flush ? '0 : pending;
    for (int w = 0; w < NWR; w++) begin
      if (clr_en[w]) pending_nxt[clr_addr[w*AW +: AW]] = 1'b0;
    end
    // Issue is applied last so a new producer outranks a same-cycle writeback.
    if (iss_en && (iss_addr != AW'(REG_ZERO))) pending_nxt[iss_addr] = 1'b1;
  end

  always_ff @(posedge g_clk) begin
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    if (!g_resetn) begin
      pending  <= '0;
      busy_any <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      busy_any <= |pending_nxt;
    end
  end

endmodule

// File: rtl/core_regfile_mp.sv
// Multi-port register file with same-cycle forwarding and RAW busy reporting.
// Optional per-register even parity is built when CORE_REGFILE_PARITY_EN is defined.
module core_regfile_mp
  import core_regfile_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  parameter int NWR   = 1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  core_regfile_if.slave bus
);

  localparam int AW = regfile_aw(NREGS);
  typedef logic [AW-1:0]   addr_t;
  typedef logic [XLEN-1:0] word_t;

  word_t                regs     [NREGS];
  logic [MAX_PORTS-1:0] wr_hit   [NREGS];
  word_t                win_data [NREGS];
  logic [NREGS-1:0]     pending;
`ifdef CORE_REGFILE_PARITY_EN
  logic                 par      [NREGS];
`endif

  // Per-register write arbitration: the highest-index enabled port targeting r wins.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      wr_hit[r] = '0;
      for (int w = 0; w < NWR; w++) begin
        wr_hit[r][w] = bus.rd_wen[w] && (bus.rd_addr[w*AW +: AW] == AW'(r));
      end
      win_data[r] = bus.rd_wdata[prio_sel(wr_hit[r])*XLEN +: XLEN];
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      // NOTE: storage is a flop array, not a RAM macro, so it can and must be cleared by reset.
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
`ifdef CORE_REGFILE_PARITY_EN
        par[r]  <= 1'b0;
`endif
      end
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (|wr_hit[r]) begin
          regs[r] <= win_data[r];
`ifdef CORE_REGFILE_PARITY_EN
          par[r]  <= ^win_data[r];
`endif
        end
      end
    end
  end

  core_regfile_sb #(
    .NREGS(NREGS),
    .NWR  (NWR),
    .AW   (AW)
  ) u_sb (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .flush   (bus.flush),
    .clr_en  (bus.rd_wen),
    .clr_addr(bus.rd_addr),
    .iss_en  (bus.iss_en),
    .iss_addr(bus.iss_addr),
    .pending (pending),
    .busy_any(bus.busy_any)
  );

  // Read ports: x0 first, then same-cycle forwarding, then storage.
  always_comb begin
    bus.rs_data = '0;
    bus.rs_busy = '0;
    bus.rs_perr = '0;
    for (int p = 0; p < NRD; p++) begin
      addr_t                a;
      logic [MAX_PORTS-1:0] fwd_hit;
      a       = bus.rs_addr[p*AW +: AW];
      fwd_hit = '0;
      for (int w = 0; w < NWR; w++) begin
        fwd_hit[w] = bus.rd_wen[w] && (bus.rd_addr[w*AW +: AW] == a);
      end
      if (a == AW'(REG_ZERO)) begin
        bus.rs_data[p*XLEN +: XLEN] = '0;
      end else if (|fwd_hit) begin
        bus.rs_data[p*XLEN +: XLEN] = bus.rd_wdata[prio_sel(fwd_hit)*XLEN +: XLEN];
      end else begin
        bus.rs_data[p*XLEN +: XLEN] = regs[a];
      end
      // A write landing this cycle resolves the hazard because its data is forwarded.
      bus.rs_busy[p] = pending[a] && !(|fwd_hit);
`ifdef CORE_REGFILE_PARITY_EN
      if ((a != AW'(REG_ZERO)) && !(|fwd_hit)) bus.rs_perr[p] = par[a] ^ (^regs[a]);
`endif
    end
  end

endmodule

// File: tb/tb_core_regfile_mp.sv
// Directed + randomized bench for core_regfile_mp against an array-level reference model.
module tb_core_regfile_mp;
  import core_regfile_pkg::*;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWR   = 2;
  localparam int AW    = 5;

  logic g_clk = 1'b0;
  logic g_resetn;
  always #5 g_clk = ~g_clk;

  core_regfile_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();

  core_regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) dut (
    .g_clk   (g_clk),
    .g_resetn(g_resetn),
    .bus     (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Stimulus for the current cycle
  logic [AW-1:0]   d_rs  [NRD];
  logic            d_wen [NWR];
  logic [AW-1:0]   d_wa  [NWR];
  logic [XLEN-1:0] d_wd  [NWR];
  logic            d_iss;
  logic [AW-1:0]   d_ia;
  logic            d_flush;

  // Architectural reference state
  logic [XLEN-1:0] m_regs    [NREGS];
  bit              m_pend    [NREGS];
  bit              m_corrupt [NREGS];

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    for (int p = 0; p < NRD; p++) d_rs[p] = '0;
    for (int w = 0; w < NWR; w++) begin
      d_wen[w] = 1'b0;
      d_wa[w]  = '0;
      d_wd[w]  = '0;
    end
    d_iss   = 1'b0;
    d_ia    = '0;
    d_flush = 1'b0;
  endtask

  task automatic drive();
    for (int p = 0; p < NRD; p++) bus.rs_addr[p*AW +: AW] = d_rs[p];
    for (int w = 0; w < NWR; w++) begin
      bus.rd_wen[w]               = d_wen[w];
      bus.rd_addr[w*AW +: AW]     = d_wa[w];
      bus.rd_wdata[w*XLEN +: XLEN] = d_wd[w];
    end
    bus.iss_en   = d_iss;
    bus.iss_addr = d_ia;
    bus.flush    = d_flush;
    #3;
  endtask

  // Highest-index enabled write port targeting a nonzero address, or -1.
  function automatic int fwd_port(input logic [AW-1:0] a);
    int f = -1;
    if (a == '0) return -1;
    for (int w = 0; w < NWR; w++) if (d_wen[w] && d_wa[w] == a) f = w;
    return f;
  endfunction

  task automatic compare_all();
    bit any_pend = 0;
    for (int r = 0; r < NREGS; r++) any_pend |= m_pend[r];
    for (int p = 0; p < NRD; p++) begin
      logic [AW-1:0]   a = d_rs[p];
      int              f = fwd_port(a);
      bit              any_w = 0;
      logic [XLEN-1:0] exp_d;
      for (int w = 0; w < NWR; w++) if (d_wen[w] && d_wa[w] == a) any_w = 1;
      exp_d = (a == '0) ? '0 : (f >= 0 ? d_wd[f] : m_regs[a]);
      check($sformatf("rs_data[%0d] x%0d", p, a), bus.rs_data[p*XLEN +: XLEN], exp_d);
      check($sformatf("rs_busy[%0d] x%0d", p, a), {63'd0, bus.rs_busy[p]},
            {63'd0, (m_pend[a] && !any_w)});
      check($sformatf("rs_perr[%0d] x%0d", p, a), {63'd0, bus.rs_perr[p]},
            {63'd0, (a != '0 && f < 0 && m_corrupt[a])});
    end
    check("busy_any", {63'd0, bus.busy_any}, {63'd0, any_pend});
  endtask

  task automatic model_edge();
    if (!g_resetn) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r]    = '0;
        m_pend[r]    = 0;
        m_corrupt[r] = 0;
      end
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (d_wen[w] && d_wa[w] != '0) begin
          m_regs[d_wa[w]]    = d_wd[w];
          m_corrupt[d_wa[w]] = 0;
        end
      end
      if (d_flush) for (int r = 0; r < NREGS; r++) m_pend[r] = 0;
      for (int w = 0; w < NWR; w++) if (d_wen[w]) m_pend[d_wa[w]] = 0;
      if (d_iss && d_ia != '0) m_pend[d_ia] = 1;
    end
  endtask

  task automatic commit();
    if (g_resetn) compare_all();
    @(posedge g_clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    drive();
    commit();
  endtask

  initial begin
    idle();
    // Reset with a write and an issue presented: both must be discarded.
    g_resetn = 1'b0;
    d_wen[0] = 1'b1; d_wa[0] = 5'd5; d_wd[0] = 64'hFFFF; d_iss = 1'b1; d_ia = 5'd9;
    step();
    step();
    g_resetn = 1'b1;
    idle();

    // Reset state on all ports
    for (int r = 1; r < NREGS; r++) begin
      d_rs[0] = AW'(r);
      d_rs[1] = AW'(NREGS - r);
      drive();
      check("reset rs_data", bus.rs_data[0 +: XLEN], 64'd0);
      check("reset busy_any", {63'd0, bus.busy_any}, 64'd0);
      commit();
    end

    // Same-cycle forwarding, then storage read
    idle();
    d_wen[0] = 1'b1; d_wa[0] = 5'd5; d_wd[0] = 64'hDEAD_BEEF; d_rs[0] = 5'd5; d_rs[1] = 5'd5;
    drive();
    check("fwd x5", bus.rs_data[0 +: XLEN], 64'hDEAD_BEEF);
    commit();
    idle(); d_rs[0] = 5'd5;
    drive();
    check("stored x5", bus.rs_data[0 +: XLEN], 64'hDEAD_BEEF);
    commit();

    // Write collision: port 1 wins
    idle();
    d_wen[0] = 1'b1; d_wa[0] = 5'd7; d_wd[0] = 64'h11;
    d_wen[1] = 1'b1; d_wa[1] = 5'd7; d_wd[1] = 64'h22; d_rs[1] = 5'd7;
    drive();
    check("collide fwd x7", bus.rs_data[XLEN +: XLEN], 64'h22);
    commit();
    idle(); d_rs[0] = 5'd7;
    drive();
    check("collide stored x7", bus.rs_data[0 +: XLEN], 64'h22);
    commit();

    // Scoreboard: issue, issue+write, write
    idle(); d_iss = 1'b1; d_ia = 5'd9; step();
    idle(); d_rs[0] = 5'd9;
    drive();
    check("x9 busy", {63'd0, bus.rs_busy[0]}, 64'd1);
    check("x9 busy_any", {63'd0, bus.busy_any}, 64'd1);
    commit();
    idle(); d_rs[0] = 5'd9; d_wen[0] = 1'b1; d_wa[0] = 5'd9; d_wd[0] = 64'h99; d_iss = 1'b1; d_ia = 5'd9;
    step();
    idle(); d_rs[0] = 5'd9; d_wen[1] = 1'b1; d_wa[1] = 5'd9; d_wd[1] = 64'h9A;
    drive();
    check("x9 still pending", {63'd0, bus.busy_any}, 64'd1);
    check("x9 resolved by write", {63'd0, bus.rs_busy[0]}, 64'd0);
    commit();
    idle(); d_rs[0] = 5'd9;
    drive();
    check("x9 clear", {63'd0, bus.rs_busy[0]}, 64'd0);
    commit();

    // Flush with concurrent issue, x0 behaviour
    idle(); d_iss = 1'b1; d_ia = 5'd3; step();
    idle(); d_iss = 1'b1; d_ia = 5'd4; step();
    idle(); d_flush = 1'b1; d_iss = 1'b1; d_ia = 5'd6; step();
    idle(); d_rs[0] = 5'd3; d_rs[1] = 5'd4; step();
    idle(); d_rs[0] = 5'd6;
    drive();
    check("x6 busy after flush", {63'd0, bus.rs_busy[0]}, 64'd1);
    commit();
    idle(); d_wen[0] = 1'b1; d_wa[0] = 5'd0; d_wd[0] = 64'hFF; d_rs[0] = 5'd0; step();
    idle(); d_rs[0] = 5'd0; step();
    idle(); d_iss = 1'b1; d_ia = 5'd0; step();
    idle(); d_rs[0] = 5'd0;
    drive();
    check("x0 not busy", {63'd0, bus.rs_busy[0]}, 64'd0);
    check("x0 reads 0", bus.rs_data[0 +: XLEN], 64'd0);
    commit();

`ifdef CORE_REGFILE_PARITY_EN
    idle(); d_wen[0] = 1'b1; d_wa[0] = 5'd2; d_wd[0] = 64'h1; step();
    dut.regs[2] = dut.regs[2] ^ 64'h8;
    m_regs[2] = m_regs[2] ^ 64'h8;
    m_corrupt[2] = 1;
    idle(); d_rs[0] = 5'd2;
    drive();
    check("parity error x2", {63'd0, bus.rs_perr[0]}, 64'd1);
    commit();
    idle(); d_rs[1] = 5'd2; d_wen[1] = 1'b1; d_wa[1] = 5'd2; d_wd[1] = 64'h3;
    drive();
    check("forwarded x2 no perr", {63'd0, bus.rs_perr[1]}, 64'd0);
    commit();
`endif

    // Randomized traffic; narrow address window half the time to force collisions
    for (int c = 0; c < 600; c++) begin
      g_resetn = ($urandom_range(0, 149) != 0);
      for (int p = 0; p < NRD; p++)
        d_rs[p] = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
      for (int w = 0; w < NWR; w++) begin
        d_wen[w] = 1'($urandom_range(0, 1));
        d_wa[w]  = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
        d_wd[w]  = {$urandom, $urandom};
      end
      d_iss   = 1'($urandom_range(0, 1));
      d_ia    = $urandom_range(0, 1) ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
      d_flush = ($urandom_range(0, 19) == 0);
      step();
    end
    g_resetn = 1'b1;
    idle();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
